// File: rtl/hilo_ctrl.sv
// hilo_ctrl: HI/LO multiply/divide controller.
// Multiplies and MTHI/MTLO write HI/LO one cycle after acceptance with no stall.
// DIV/DIVU run a 32-iteration restoring divider and write HI/LO 33 cycles
// after acceptance, holding the pipeline (stall) until the write cycle.
//
// Handshake: a request (start, op, a, b) is taken in a cycle where the FSM is
// IDLE, start=1, flush=0 and op is 0..5; otherwise it is dropped with no
// effect. There is no ready output; the pipeline must hold the instruction
// while stall=1. hilo_we is a single-cycle strobe that qualifies hi_w/lo_w,
// and flush suppresses it in the cycle flush is high.
module hilo_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi_cur,
  input  logic [31:0] lo_cur,
  input  logic        flush,
  output logic        stall,
  output logic        hilo_we,
  output logic [31:0] hi_w,
  output logic [31:0] lo_w
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DIV_RUN = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  state_t      state, state_nxt;
  logic [5:0]  cnt;

  // Divider working registers
  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvs_q;
  logic [31:0] a_q;
  logic        neg_q;
  logic        neg_r;
  logic        div0_q;

  // Pending one-cycle write for multiply / move operations
  logic        wr_pend_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;

  // Request decode
  logic        accept;
  logic        is_div;
  logic        accept_div;
  logic        accept_wr;
  logic        last_iter;

  assign is_div     = (op == OP_DIV) || (op == OP_DIVU);
  assign accept     = (state == IDLE) && start && !flush && (op <= OP_MTLO);
  assign accept_div = accept && is_div;
  assign accept_wr  = accept && !is_div;
  assign last_iter  = (cnt == 6'd31);

  // Multiplier: sign-extend for MULT, zero-extend for MULTU
  logic        mul_signed;
  logic [63:0] mul_a_ext;
  logic [63:0] mul_b_ext;
  logic [63:0] product;

  assign mul_signed = (op == OP_MULT);
  assign mul_a_ext  = {{32{a[31] & mul_signed}}, a};
  assign mul_b_ext  = {{32{b[31] & mul_signed}}, b};
  assign product    = mul_a_ext * mul_b_ext;

  // Operand magnitudes for the divider (signed DIV only)
  logic        div_signed;
  logic [31:0] a_mag;
  logic [31:0] b_mag;

  assign div_signed = (op == OP_DIV);
  assign a_mag      = (div_signed && a[31]) ? (~a + 32'd1) : a;
  assign b_mag      = (div_signed && b[31]) ? (~b + 32'd1) : b;

  // One restoring-division step: shift in next dividend bit, trial subtract
  logic [32:0] trial;
  logic [31:0] rem_nxt;
  logic [31:0] quo_nxt;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  assign trial   = {rem_q, quo_q[31]} - {1'b0, dvs_q};
  assign rem_nxt = trial[32] ? {rem_q[30:0], quo_q[31]} : trial[31:0];
  assign quo_nxt = {quo_q[30:0], ~trial[32]};
  assign q_fix   = neg_q ? (~quo_nxt + 32'd1) : quo_nxt;
  assign r_fix   = neg_r ? (~rem_nxt + 32'd1) : rem_nxt;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; flush returns to IDLE from anywhere
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_div) state_nxt = DIV_RUN;
      DIV_RUN: if (last_iter)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Outputs: stall covers the divide acceptance cycle and every DIV_RUN cycle
  always_comb begin
    stall   = 1'b0;
    hilo_we = 1'b0;
    if (!rst && !flush) begin
      stall   = (state == DIV_RUN) || accept_div;
      hilo_we = (state == DONE) || wr_pend_q;
    end
  end

  // Iteration counter: counts DIV_RUN cycles, zero elsewhere
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= 6'd0;
    end else if ((state == DIV_RUN) && !flush) begin
      cnt <= cnt + 6'd1;
    end else begin
      cnt <= 6'd0;
    end
  end

  // Divider datapath: latch operands on acceptance, iterate in DIV_RUN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q  <= 32'd0;
      quo_q  <= 32'd0;
      dvs_q  <= 32'd0;
      a_q    <= 32'd0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0_q <= 1'b0;
    end else if (accept_div) begin
      rem_q  <= 32'd0;
      quo_q  <= a_mag;
      dvs_q  <= b_mag;
      a_q    <= a;
      neg_q  <= div_signed && (a[31] ^ b[31]);
      neg_r  <= div_signed && a[31];
      div0_q <= (b == 32'd0);
    end else if ((state == DIV_RUN) && !flush) begin
      rem_q  <= rem_nxt;
      quo_q  <= quo_nxt;
    end
  end

  // Result registers: loaded on multiply/move acceptance or final divide step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_pend_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      wr_pend_q <= accept_wr;
      if (accept_wr) begin
        case (op)
          OP_MULT, OP_MULTU: begin
            hi_q <= product[63:32];
            lo_q <= product[31:0];
          end
          OP_MTHI: begin
            hi_q <= a;
            lo_q <= lo_cur;
          end
          default: begin
            hi_q <= hi_cur;
            lo_q <= a;
          end
        endcase
      end else if ((state == DIV_RUN) && !flush && last_iter) begin
        hi_q <= div0_q ? a_q : r_fix;
        lo_q <= div0_q ? 32'hFFFF_FFFF : q_fix;
      end
    end
  end

  assign hi_w = hi_q;
  assign lo_w = lo_q;

endmodule

// File: tb/tb_hilo_ctrl.sv
// Directed testbench for hilo_ctrl. Inputs change 1ns after posedge;
// outputs are checked 2ns after posedge.
module tb_hilo_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi_cur;
  logic [31:0] lo_cur;
  logic        flush;
  logic        stall;
  logic        hilo_we;
  logic [31:0] hi_w;
  logic [31:0] lo_w;

  int checks   = 0;
  int failures = 0;

  hilo_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .op      (op),
    .a       (a),
    .b       (b),
    .hi_cur  (hi_cur),
    .lo_cur  (lo_cur),
    .flush   (flush),
    .stall   (stall),
    .hilo_we (hilo_we),
    .hi_w    (hi_w),
    .lo_w    (lo_w)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1ns after the next rising edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a divide, count stall cycles, check the single write
  task automatic run_div(input string tag, input logic [2:0] o, input logic [31:0] va,
                         input logic [31:0] vb, input logic [31:0] exp_hi,
                         input logic [31:0] exp_lo);
    int  n;
    bit  saw_we;
    n      = 1;
    saw_we = 1'b0;
    step();
    start = 1'b1; op = o; a = va; b = vb;
    #1;
    chk({tag, "_accept_stall"}, 64'(stall), 64'd1);
    for (int i = 0; i < 40; i++) begin
      step();
      start = 1'b0;
      #1;
      if (!stall) break;
      n++;
      if (hilo_we) saw_we = 1'b1;
    end
    chk({tag, "_stall_cycles"}, 64'(n), 64'd33);
    chk({tag, "_early_we"}, 64'(saw_we), 64'd0);
    chk({tag, "_we"}, 64'(hilo_we), 64'd1);
    chk({tag, "_hi"}, 64'(hi_w), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(lo_w), 64'(exp_lo));
    step();
    #1;
    chk({tag, "_we_once"}, 64'(hilo_we), 64'd0);
    chk({tag, "_hold_hi"}, 64'(hi_w), 64'(exp_hi));
  endtask

  // One-cycle write operations (MULT/MULTU/MTHI/MTLO)
  task automatic run_wr(input string tag, input logic [2:0] o, input logic [31:0] va,
                        input logic [31:0] vb, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    step();
    start = 1'b1; op = o; a = va; b = vb;
    #1;
    chk({tag, "_acc_stall"}, 64'(stall), 64'd0);
    chk({tag, "_acc_we"}, 64'(hilo_we), 64'd0);
    step();
    start = 1'b0;
    #1;
    chk({tag, "_we"}, 64'(hilo_we), 64'd1);
    chk({tag, "_stall"}, 64'(stall), 64'd0);
    chk({tag, "_hi"}, 64'(hi_w), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(lo_w), 64'(exp_lo));
    step();
    #1;
    chk({tag, "_we_once"}, 64'(hilo_we), 64'd0);
  endtask

  initial begin
    int  n_we;
    int  n_stall;
    rst = 1'b0; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    hi_cur = 32'd0; lo_cur = 32'd0; flush = 1'b0;

    // Reset state, including a divide request that must not raise stall
    #1 rst = 1'b1;
    start = 1'b1; op = 3'd2; b = 32'd3;
    #1;
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_we", 64'(hilo_we), 64'd0);
    chk("rst_hi", 64'(hi_w), 64'd0);
    chk("rst_lo", 64'(lo_w), 64'd0);
    start = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Multiplies
    run_wr("mult_neg2x3", 3'd0, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_wr("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_wr("mult_max", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);

    // Moves
    hi_cur = 32'h0000_AAAA; lo_cur = 32'h0000_5555;
    run_wr("mtlo", 3'd5, 32'h0000_1234, 32'd0, 32'h0000_AAAA, 32'h0000_1234);
    run_wr("mthi", 3'd4, 32'h0000_CAFE, 32'd0, 32'h0000_CAFE, 32'h0000_5555);

    // Reserved opcode: ignored
    step();
    start = 1'b1; op = 3'd7; a = 32'h1111_1111;
    #1;
    chk("op7_stall", 64'(stall), 64'd0);
    step();
    start = 1'b0;
    #1;
    chk("op7_we", 64'(hilo_we), 64'd0);
    chk("op7_hold_hi", 64'(hi_w), 64'h0000_CAFE);
    chk("op7_hold_lo", 64'(lo_w), 64'h0000_5555);

    // Divides
    run_div("divu_100_7", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
    run_div("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_div("div_min_m1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    run_div("div_7_m2", 3'd2, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);
    run_div("divu_max_10", 3'd3, 32'hFFFF_FFFF, 32'd10, 32'd5, 32'h1999_9999);
    run_div("divu_5_0", 3'd3, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    run_div("div_m9_0", 3'd2, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF);

    // Flush at DIV_RUN cycle 10; a start during DIV_RUN is ignored
    step();
    start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
    #1;
    chk("fl_accept_stall", 64'(stall), 64'd1);
    for (int i = 1; i < 10; i++) begin
      step();
      start = (i == 5); op = 3'd0; a = 32'd3; b = 32'd3;
      #1;
    end
    chk("fl_run_stall", 64'(stall), 64'd1);
    chk("fl_run_we", 64'(hilo_we), 64'd0);
    step();
    flush = 1'b1;
    #1;
    chk("fl_stall_drop", 64'(stall), 64'd0);
    chk("fl_we", 64'(hilo_we), 64'd0);
    step();
    flush = 1'b0;
    n_we = 0; n_stall = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (hilo_we) n_we++;
      if (stall) n_stall++;
      step();
    end
    chk("fl_no_write", 64'(n_we), 64'd0);
    chk("fl_no_stall", 64'(n_stall), 64'd0);
    run_wr("fl_after_mult", 3'd0, 32'd6, 32'd7, 32'd0, 32'd42);

    // Flush during the pending multiply write
    step();
    start = 1'b1; op = 3'd1; a = 32'd9; b = 32'd9;
    step();
    start = 1'b0; flush = 1'b1;
    #1;
    chk("flm_we", 64'(hilo_we), 64'd0);
    step();
    flush = 1'b0;
    #1;
    chk("flm_we_after", 64'(hilo_we), 64'd0);

    // Reset mid-division
    step();
    start = 1'b1; op = 3'd3; a = 32'd100; b = 32'd7;
    for (int i = 0; i < 5; i++) begin
      step();
      start = 1'b0;
    end
    rst = 1'b1;
    #1;
    chk("rmid_stall", 64'(stall), 64'd0);
    chk("rmid_hi", 64'(hi_w), 64'd0);
    chk("rmid_lo", 64'(lo_w), 64'd0);
    step();
    rst = 1'b0;
    n_we = 0; n_stall = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (hilo_we) n_we++;
      if (stall) n_stall++;
      step();
    end
    chk("rmid_no_write", 64'(n_we), 64'd0);
    chk("rmid_no_stall", 64'(n_stall), 64'd0);

    // Normal operation after reset
    run_div("post_rst_divu", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global time limit
  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hilo_ctrl.md
HILO_CTRL -- requirements
Module: hilo_ctrl

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request valid for op/a/b this cycle.
REQ-005 op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved.
REQ-006 a  input  32  rs operand (dividend / multiplicand / MTHI-MTLO source).
REQ-007 b  input  32  rt operand (divisor / multiplier).
REQ-008 hi_cur, lo_cur  input  32 each  current HI/LO register contents.
REQ-009 flush  input  1  pipeline flush (exception); cancels pending work.
REQ-010 stall  output  1  pipeline must hold while high.
REQ-011 hilo_we  output  1  write strobe to the HI/LO register.
REQ-012 hi_w, lo_w  output  32 each  values to write when hilo_we=1.

Function
REQ-013 FSM states SHALL be IDLE, DIV_RUN, DONE; a request is accepted only in IDLE with start=1, flush=0 and op in 0..5.
REQ-014 start with op 6/7, or any start outside IDLE, SHALL be ignored with no state change and no write.
REQ-015 MULT/MULTU SHALL write the 64-bit signed/unsigned product {hi_w,lo_w} with hilo_we=1 exactly once, in the cycle after acceptance; stall stays 0.
REQ-016 MTHI SHALL write hi_w=a, lo_w=lo_cur (sampled at acceptance); MTLO SHALL write hi_w=hi_cur, lo_w=a; one-cycle latency as REQ-015, stall 0.
REQ-017 DIV/DIVU acceptance SHALL move IDLE->DIV_RUN, latching a and b; stall SHALL be high combinationally in the acceptance cycle and in every DIV_RUN cycle.
REQ-018 DIV_RUN SHALL perform one restoring-division iteration per cycle for exactly 32 cycles on 32-bit magnitudes, using a 6-bit iteration counter, then move to DONE.
REQ-019 In DONE, hilo_we SHALL be 1 for one cycle with lo_w=quotient and hi_w=remainder, stall SHALL be 0, and the next state SHALL be IDLE; total latency is 33 cycles from acceptance to write.
REQ-020 DIV signed rules: the quotient is negated when the operand signs differ; the remainder takes the dividend's sign; 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000, hi=0.
REQ-021 Divide by zero (either op) SHALL keep the 33-cycle latency and write hi_w=a, lo_w=0xFFFFFFFF.
REQ-022 flush SHALL have priority: in any flush cycle hilo_we is forced to 0, stall is 0, the FSM goes to IDLE and any pending write is discarded.
REQ-023 hi_w/lo_w SHALL hold their last values when hilo_we=0; no more than one write is ever issued per accepted request.

Reset
REQ-024 While rst=1 (asynchronous), the state SHALL be IDLE, the counter 0, and stall, hilo_we, hi_w and lo_w all 0.
REQ-025 Reset asserted mid-division SHALL abandon the operation; no write is issued after deassertion.

Verification
REQ-026 MULT a=0xFFFFFFFE (-2), b=3 -> next cycle hilo_we=1, hi_w=0xFFFFFFFF, lo_w=0xFFFFFFFA, stall never high.
REQ-027 DIVU a=100, b=7 -> stall high for 33 cycles (acceptance plus 32), then one cycle hilo_we=1, lo_w=14, hi_w=2.
REQ-028 DIV a=-7 (0xFFFFFFF9), b=2 -> after 33 cycles lo_w=0xFFFFFFFD, hi_w=0xFFFFFFFF; DIV 0x80000000 / -1 -> lo_w=0x80000000, hi_w=0.
REQ-029 DIVU a=5, b=0 -> write after 33 cycles with hi_w=5, lo_w=0xFFFFFFFF.
REQ-030 DIV started, flush asserted at DIV_RUN cycle 10 -> stall drops the same cycle, no hilo_we, and the next start is accepted normally.
REQ-031 MTLO a=0x1234 with hi_cur=0xAAAA -> next cycle hi_w=0xAAAA, lo_w=0x1234; start with op=7 -> no write, no stall.
